// File: rtl/arbiter_puf_eval.sv
// Arbiter PUF evaluator: drives a challenge-selected delay chain with a pulse,
// majority-votes N_EVAL arbiter samples per bit and assembles a response word.
module arbiter_puf_eval #(
  parameter int N_STAGES   = 16,
  parameter int N_EVAL     = 5,
  parameter int RESP_BITS  = 8,
  parameter int SETTLE_CYC = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_STAGES-1:0]  challenge,
  input  logic                 test_en,
  input  logic                 test_bit,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 unstable,
  output logic [N_STAGES-1:0]  cur_challenge,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int SW = $clog2(SETTLE_CYC);
  localparam int EW = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;
  localparam int OW = $clog2(N_EVAL + 1);
  localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [EW-1:0] EVAL_LAST   = EW'(N_EVAL - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);
  localparam logic [OW-1:0] VOTE_HALF   = OW'(N_EVAL / 2);
  localparam logic [OW-1:0] VOTE_FULL   = OW'(N_EVAL);

  logic [2:0]           state, state_n;
  logic                 pulse_q;
  logic [SW-1:0]        settle_cnt;
  logic [EW-1:0]        eval_cnt;
  logic [BW-1:0]        bit_idx;
  logic [OW-1:0]        ones_cnt;
  logic [RESP_BITS-1:0] shadow;
  logic                 unst_shadow;
  logic [1:0]           sync_q;
  logic                 arb_q;
  logic [1:0]           chain_out;

  // Each stage passes the two paths straight on a 0 bit and crosses them on a 1.
  function automatic logic [1:0] chain_eval(input logic p, input logic [N_STAGES-1:0] c);
    logic top, bot, tmp;
    top = p;
    bot = p;
    for (int i = 0; i < N_STAGES; i++) begin
      tmp = top;
      top = c[i] ? bot : top;
      bot = c[i] ? tmp : bot;
    end
    return {top, bot};
  endfunction

  assign chain_out = chain_eval(pulse_q, cur_challenge);

  // The arbiter races the two paths: the top edge samples the bottom level.
  always_ff @(posedge chain_out[1]) begin
    arb_q <= chain_out[0];
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], test_en ? test_bit : arb_q};
  end

  logic last_settle, last_eval, last_bit, commit, bit_val, bit_split;
  logic [RESP_BITS-1:0] shadow_n;
  logic                 unst_n;
  logic [N_STAGES-1:0]  chal_step;

  assign last_settle = (settle_cnt == SETTLE_LAST);
  assign last_eval   = (eval_cnt == EVAL_LAST);
  assign last_bit    = (bit_idx == BIT_LAST);
  assign commit      = (state == S_RELEASE) && last_settle && last_eval;
  assign bit_val     = (ones_cnt > VOTE_HALF);
  assign bit_split   = (ones_cnt != '0) && (ones_cnt != VOTE_FULL);
  assign shadow_n    = (shadow << 1) | RESP_BITS'(bit_val);
  assign unst_n      = unst_shadow | bit_split;
  assign chal_step   = {cur_challenge[N_STAGES-2:0],
                        cur_challenge[N_STAGES-1] ^ cur_challenge[N_STAGES/2-1]};

  // Request protocol: start is taken only in IDLE; busy covers the run, and
  // done pulses for one cycle with response/unstable already valid.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_LAUNCH;
      S_LAUNCH:  if (last_settle) state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_RELEASE;
      S_RELEASE: if (last_settle) state_n = (last_eval && last_bit) ? S_DONE : S_LAUNCH;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pulse_q       <= 1'b0;
      settle_cnt    <= '0;
      eval_cnt      <= '0;
      bit_idx       <= '0;
      ones_cnt      <= '0;
      shadow        <= '0;
      unst_shadow   <= 1'b0;
      response      <= '0;
      unstable      <= 1'b0;
      cur_challenge <= '0;
    end else begin
      state   <= state_n;
      pulse_q <= (state_n == S_LAUNCH) || (state_n == S_CAPTURE);

      if (((state == S_LAUNCH) || (state == S_RELEASE)) && !last_settle)
        settle_cnt <= settle_cnt + 1'b1;
      else
        settle_cnt <= '0;

      if (state == S_IDLE && start) begin
        cur_challenge <= challenge;
        ones_cnt      <= '0;
        eval_cnt      <= '0;
        bit_idx       <= '0;
        shadow        <= '0;
        unst_shadow   <= 1'b0;
      end

      if (state == S_CAPTURE && sync_q[1])
        ones_cnt <= ones_cnt + 1'b1;

      if (state == S_RELEASE && last_settle) begin
        if (last_eval) begin
          eval_cnt      <= '0;
          ones_cnt      <= '0;
          shadow        <= shadow_n;
          unst_shadow   <= unst_n;
          cur_challenge <= chal_step;
          bit_idx       <= bit_idx + 1'b1;
          // Final commit publishes straight to the outputs so done sees them.
          if (last_bit) begin
            response <= shadow_n;
            unstable <= unst_n;
          end
        end else begin
          eval_cnt <= eval_cnt + 1'b1;
        end
      end
    end
  end

  assign busy      = (state == S_LAUNCH) || (state == S_CAPTURE) || (state == S_RELEASE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  logic unused_ok;
  assign unused_ok = commit;

endmodule

// File: tb/tb_arbiter_puf_eval.sv
// Bench for arbiter_puf_eval: per-evaluation test_bit patterns are fed through
// the test path and the response is predicted from vote counts per bit.
module tb_arbiter_puf_eval;

  localparam int N      = 16;
  localparam int NE     = 5;
  localparam int RB     = 8;
  localparam int SC     = 3;
  localparam int NEVALS = RB * NE;
  localparam int EVC    = 2 * SC + 1;
  localparam int LAT    = NEVALS * EVC + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  challenge;
  logic          test_en;
  logic          test_bit;
  logic          busy;
  logic          done;
  logic [RB-1:0] response;
  logic          unstable;
  logic [N-1:0]  cur_challenge;
  logic [2:0]    state_dbg;

  arbiter_puf_eval #(.N_STAGES(N), .N_EVAL(NE), .RESP_BITS(RB), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .test_en(test_en), .test_bit(test_bit), .busy(busy), .done(done),
    .response(response), .unstable(unstable), .cur_challenge(cur_challenge),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic          pat[NEVALS];
  logic [RB-1:0] m_resp = '0;
  logic          m_unst = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] step_ch(input logic [N-1:0] c, input int n);
    logic [N-1:0] r;
    r = c;
    for (int i = 0; i < n; i++) r = {r[N-2:0], r[N-1] ^ r[N/2-1]};
    return r;
  endfunction

  task automatic fill_const(input logic v);
    for (int i = 0; i < NEVALS; i++) pat[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NEVALS; i++) pat[i] = 1'($urandom_range(0, 1));
  endtask

  // Exactly k of the NE evaluations of every bit see a 1, at random positions.
  task automatic fill_k_of(input int k);
    for (int b = 0; b < RB; b++) begin
      int placed;
      for (int e = 0; e < NE; e++) pat[b*NE+e] = 1'b0;
      placed = 0;
      while (placed < k) begin
        int j;
        j = $urandom_range(0, NE - 1);
        if (!pat[b*NE+j]) begin
          pat[b*NE+j] = 1'b1;
          placed++;
        end
      end
    end
  endtask

  // driver: one request; abort_at > 0 pulses rst at that cycle instead of finishing
  task automatic run(input logic [N-1:0] ch, input int abort_at);
    logic [RB-1:0] exp_r;
    logic          exp_u;
    logic [N-1:0]  exp_ch, mid_ch;
    logic          aborted;
    int            last;
    exp_r = '0;
    exp_u = 1'b0;
    for (int b = 0; b < RB; b++) begin
      int ones;
      ones = 0;
      for (int e = 0; e < NE; e++) ones += int'(pat[b*NE+e]);
      exp_r = {exp_r[RB-2:0], (ones > NE / 2)};
      if (ones != 0 && ones != NE) exp_u = 1'b1;
    end
    exp_ch  = step_ch(ch, RB);
    mid_ch  = step_ch(ch, 1);
    aborted = 1'b0;
    last    = (abort_at > 0) ? abort_at + 5 : LAT + 1;

    start = 1'b1;
    challenge = ch;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    challenge = N'($urandom);
    for (int k = 1; k <= last; k++) begin
      if (aborted) begin
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_resp", response, 0);
        check("abort_unst", unstable, 0);
        if (k == abort_at + 1) check("abort_chal", cur_challenge, 0);
      end else begin
        check("busy", busy, (k < LAT));
        check("done", done, (k == LAT));
        check("response", response, (k >= LAT) ? exp_r : m_resp);
        check("unstable", unstable, (k >= LAT) ? exp_u : m_unst);
        if (k == LAT) check("final_chal", cur_challenge, exp_ch);
        if (k == 52 && k < LAT) check("chal_after_ignored_start", cur_challenge, mid_ch);
      end
      if ((k - 1) % EVC == 0 && (k - 1) / EVC < NEVALS) test_bit = pat[(k-1)/EVC];
      start = (k == 50);
      challenge = N'($urandom);
      if (abort_at > 0 && k == abort_at) begin
        rst = 1'b1;
        aborted = 1'b1;
      end
      if (abort_at > 0 && k == abort_at + 1) rst = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
    if (aborted) begin
      m_resp = '0;
      m_unst = 1'b0;
    end else begin
      m_resp = exp_r;
      m_unst = exp_u;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_en = 1'b1;
    test_bit = 1'b0;
    challenge = '0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_resp", response, 0);
    check("rst_unst", unstable, 0);
    check("rst_chal", cur_challenge, 0);

    fill_const(1'b1);
    run(16'h0001, 0);
    check("ones_chal_0101", cur_challenge, 16'h0101);
    check("ones_resp_ff", response, 8'hFF);

    fill_const(1'b0);
    run(N'($urandom), 0);
    check("zeros_resp", response, 8'h00);

    fill_k_of(3);
    run(N'($urandom), 0);
    check("split3_resp", response, 8'hFF);
    check("split3_unst", unstable, 1);

    fill_k_of(2);
    run(N'($urandom), 0);
    check("split2_resp", response, 8'h00);
    check("split2_unst", unstable, 1);

    fill_rand();
    run(N'($urandom), 100);

    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run(N'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
